mcu_seq: RTL

- Host-side sequencer that drives the convolution memory control unit (MCU). It is the other end of the MCU's pixel/address/framing interface.
- Accepts a column-major pixel stream from the host and generates write data, write address and column framing (sop/eop) into the MCU's N+2 column memories.
- Pulses chblk to switch the MCU to convolution, then sweeps the read address and collects the MCU's serialized results for one block.

---
 rtl/mcu_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/mcu_seq.sv
// Host-side sequencer for the convolution MCU: loads N+2 pixel columns, pulses chblk,
// sweeps the read rows and collects the serialized results of one block.
module mcu_seq #(
  parameter int N           = 16,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  parameter int BITS_ADDR   = 10,
  parameter int CONV_LAT    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [BITS_ADDR-1:0]   i_rows,
  input  logic [BITS_IMAGEN-1:0] i_pix,
  input  logic                   i_pix_valid,
  output logic                   o_pix_ready,
  output logic [BITS_IMAGEN-1:0] o_Data,
  output logic [BITS_ADDR-1:0]   o_WAddr,
  output logic [BITS_ADDR-1:0]   o_RAddr,
  output logic                   o_sop,
  output logic                   o_eop,
  output logic                   o_chblk,
  input  logic [BITS_DATA-1:0]   i_res,
  output logic [BITS_DATA-1:0]   o_res,
  output logic                   o_res_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int CLW = $clog2(N + 2);
  localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(N + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SWITCH, CONV, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [BITS_ADDR-1:0]   rows_q, rows_d;
  logic [BITS_ADDR-1:0]   row_q, row_d;
  logic [CLW-1:0]         col_q, col_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          rem_q, rem_d;
  logic [CONV_LAT-1:0]    sr_q, sr_d, sr_shift;
  logic                   pix_ready_q, pix_ready_d;
  logic [BITS_IMAGEN-1:0] data_q, data_d;
  logic [BITS_ADDR-1:0]   waddr_q, waddr_d;
  logic [BITS_ADDR-1:0]   raddr_q, raddr_d;
  logic                   sop_q, sop_d, eop_q, eop_d, chblk_q, chblk_d;
  logic [BITS_DATA-1:0]   res_q, res_d;
  logic                   res_valid_q, res_valid_d, busy_q, busy_d, done_q, done_d;

  logic accept, start_now, active, pending, last_row;

  assign accept    = pix_ready_q & i_pix_valid;
  assign last_row  = (row_q == rows_q - 1'b1);
  // Rows 0 and 1 only prime the MCU window; results start with read 2.
  assign start_now = (state_q == CONV) && (cnt_q == '0) && (raddr_q >= BITS_ADDR'(2));
  assign active    = sr_q[CONV_LAT-1] | (rem_q != '0);
  assign pending   = (|sr_q) | (rem_q != '0);

  genvar gi;
  generate
    for (gi = 0; gi < CONV_LAT; gi++) begin : g_sr
      if (gi == 0) begin : g_head
        assign sr_shift[gi] = start_now;
      end else begin : g_tail
        assign sr_shift[gi] = sr_q[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    pix_ready_d = pix_ready_q;
    data_d      = data_q;
    waddr_d     = waddr_q;
    raddr_d     = raddr_q;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    chblk_d     = 1'b0;
    done_d      = 1'b0;
    sr_d        = sr_shift;
    rem_d       = rem_q;
    res_d       = res_q;
    res_valid_d = active;

    case (state_q)
      IDLE: begin
        if (i_start && (i_rows >= BITS_ADDR'(3))) begin
          rows_d      = i_rows;
          row_d       = '0;
          col_d       = '0;
          pix_ready_d = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          data_d  = i_pix;
          waddr_d = row_q;
          sop_d   = (row_q == '0);
          eop_d   = last_row;
          if (last_row) begin
            row_d = '0;
            if (col_q == COL_LAST) begin
              pix_ready_d = 1'b0;
              state_d     = SWITCH;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      SWITCH: begin
        chblk_d = 1'b1;
        raddr_d = '0;
        cnt_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (raddr_q == rows_q - 1'b1) state_d = DRAIN;
          else                          raddr_d = raddr_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // Nothing left in flight means the final result is on o_res this cycle.
        if (!pending) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (sr_q[CONV_LAT-1])  rem_d = CNT_LAST;
    else if (rem_q != '0)  rem_d = rem_q - 1'b1;
    if (active)            res_d = i_res;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rows_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      sr_q        <= '0;
      pix_ready_q <= 1'b0;
      data_q      <= '0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      chblk_q     <= 1'b0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sr_q        <= sr_d;
      pix_ready_q <= pix_ready_d;
      data_q      <= data_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      chblk_q     <= chblk_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_pix_ready = pix_ready_q;
  assign o_Data      = data_q;
  assign o_WAddr     = waddr_q;
  assign o_RAddr     = raddr_q;
  assign o_sop       = sop_q;
  assign o_eop       = eop_q;
  assign o_chblk     = chblk_q;
  assign o_res       = res_q;
  assign o_res_valid = res_valid_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule
